// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundles the controller <-> datapath/memory signals of the Extended-MIPS
// multi-cycle core.
//   Datapath -> controller : opcode, funct (IR fields), z (ALU zero flag),
//                            mem_ready (memory completes access this cycle)
//   Controller -> datapath : mem_req, mem_we, iord, ir_write, pc_write,
//                            pc_src, alu_src_a, alu_src_b, zero_ext,
//                            alu_cont, reg_write, reg_dst, mem_to_reg,
//                            illegal, state (debug)
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       z;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_cont;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, z, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, zero_ext, alu_cont, reg_write,
               reg_dst, mem_to_reg, illegal, state
    );

    modport slave (
        output opcode, funct, z, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, zero_ext, alu_cont, reg_write,
               reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle main controller for the Extended-MIPS datapath. Sequences each
// instruction through FETCH / DECODE / execute / memory / writeback states and
// drives datapath muxes, register-file and memory strobes. Memory accesses use
// a req/ready handshake; FETCH, MEM_RD and MEM_WR stall until mem_ready.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset; forces state IDLE and all
//             outputs to 0 while low
//   ctrl_if - master modport of mips_multicycle_ctrl_if (see that file)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_multicycle_ctrl_if.master        ctrl_if
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e state_q, state_d;
    // Set on the first edge after reset release; IDLE waits on it so the
    // first FETCH starts on the second rising edge after release.
    logic   rst_done_q;

    logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
    logic [1:0] pc_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       zero_ext_s;
    logic [2:0] alu_cont_s;
    logic       reg_write_s, reg_dst_s, mem_to_reg_s, illegal_s;

    // State register and reset-release marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    // Next-state and per-state datapath control.
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 2'b00;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        zero_ext_s   = 1'b0;
        alu_cont_s   = ALU_ADD;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        illegal_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rst_done_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // PC + 4 computed while the instruction is read.
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = ctrl_if.mem_ready;
                pc_write_s  = ctrl_if.mem_ready;
                if (ctrl_if.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                alu_src_b_s = 2'b11;
                case (ctrl_if.opcode)
                    OP_RTYPE:                          state_d = S_R_EXEC;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (ctrl_if.opcode == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (ctrl_if.opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (ctrl_if.mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                iord_s    = 1'b1;
                if (ctrl_if.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_R_EXEC: begin
                alu_src_a_s = 1'b1;
                state_d     = S_R_WB;
                case (ctrl_if.funct)
                    6'h20:   alu_cont_s = ALU_ADD;
                    6'h22:   alu_cont_s = ALU_SUB;
                    6'h24:   alu_cont_s = ALU_AND;
                    6'h25:   alu_cont_s = ALU_OR;
                    6'h27:   alu_cont_s = ALU_NOR;
                    6'h2A:   alu_cont_s = ALU_SLT;
                    default: begin
                        // Unknown funct: skip writeback entirely.
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                state_d     = S_I_WB;
                case (ctrl_if.opcode)
                    OP_ANDI: begin
                        alu_cont_s = ALU_AND;
                        zero_ext_s = 1'b1;
                    end
                    OP_ORI: begin
                        alu_cont_s = ALU_OR;
                        zero_ext_s = 1'b1;
                    end
                    OP_SLTI: alu_cont_s = ALU_SLT;
                    default: alu_cont_s = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_cont_s  = ALU_SUB;
                pc_src_s    = 2'b01;
                state_d     = S_FETCH;
                if (ctrl_if.opcode == OP_BEQ) begin
                    pc_write_s = ctrl_if.z;
                end else if (ctrl_if.opcode == OP_BNE) begin
                    pc_write_s = ~ctrl_if.z;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero while reset is held so no strobe (in
    // particular mem_we) survives an abandoned access.
    assign ctrl_if.mem_req    = rst_n & mem_req_s;
    assign ctrl_if.mem_we     = rst_n & mem_we_s;
    assign ctrl_if.iord       = rst_n & iord_s;
    assign ctrl_if.ir_write   = rst_n & ir_write_s;
    assign ctrl_if.pc_write   = rst_n & pc_write_s;
    assign ctrl_if.pc_src     = rst_n ? pc_src_s    : 2'b00;
    assign ctrl_if.alu_src_a  = rst_n & alu_src_a_s;
    assign ctrl_if.alu_src_b  = rst_n ? alu_src_b_s : 2'b00;
    assign ctrl_if.zero_ext   = rst_n & zero_ext_s;
    assign ctrl_if.alu_cont   = rst_n ? alu_cont_s  : 3'b000;
    assign ctrl_if.reg_write  = rst_n & reg_write_s;
    assign ctrl_if.reg_dst    = rst_n & reg_dst_s;
    assign ctrl_if.mem_to_reg = rst_n & mem_to_reg_s;
    assign ctrl_if.illegal    = rst_n & illegal_s;
    assign ctrl_if.state      = state_q;

endmodule
